// File: rtl/dcache_dm_rv32_pkg.sv
// Shared definitions for the RV32 D-cache: FSM encodings, bus op codes and the byte-merge helper.
package dcache_dm_rv32_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic       BUS_OP_READ  = 1'b0;
  localparam logic       BUS_OP_WRITE = 1'b1;
  localparam logic [3:0] BE_ALL       = 4'hF;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = newWord[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_dm_rv32_store.sv
// Data/tag/valid storage for the direct-mapped D-cache: async read port, byte-enable write,
// tag+valid install and single-cycle flush-all.
module dcache_dm_rv32_store
  import dcache_dm_rv32_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 27
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [31:0]      rdData,
  output logic [TAG_W-1:0] rdTag,
  output logic             rdValid,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [3:0]       wrBe,
  input  logic [31:0]      wrData,
  input  logic             tagWe,
  input  logic [TAG_W-1:0] wrTag,
  input  logic             flush
);

  logic [31:0]      dataArr [DEPTH];
  logic [TAG_W-1:0] tagArr  [DEPTH];
  logic [DEPTH-1:0] validArr;

  // NOTE: data and tag arrays are deliberately left unreset so they map onto plain RAM;
  // the valid bits alone make their power-up contents harmless.
  always_ff @(posedge iCLK) begin
    if (wrEn) dataArr[wrIdx] <= mergeBytes(dataArr[wrIdx], wrData, wrBe);
  end

  always_ff @(posedge iCLK) begin
    if (tagWe) tagArr[wrIdx] <= wrTag;
  end

  always_ff @(posedge iCLK) begin
    if (iRST || flush) validArr <= '0;
    else if (tagWe)    validArr[wrIdx] <= 1'b1;
  end

  assign rdData  = dataArr[rdIdx];
  assign rdTag   = tagArr[rdIdx];
  assign rdValid = validArr[rdIdx];

endmodule

// File: rtl/dcache_dm_rv32.sv
// Direct-mapped, write-through, no-write-allocate RV32 data cache: hit compare, miss/write FSM
// and registered bus request port.
module dcache_dm_rv32
  import dcache_dm_rv32_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iMEM,
  input  logic              iRW,
  input  logic [ADDR_W-1:0] iMEMADDR,
  input  logic [31:0]       iMEMDATA,
  input  logic [3:0]        iBE,
  output logic [31:0]       oMEMDATA,
  output logic              oStallD,
  output logic              oBUS_REQ,
  output logic              oBUS_WE,
  output logic [ADDR_W-1:0] oBUS_ADDR,
  output logic [31:0]       oBUS_WDATA,
  output logic [3:0]        oBUS_BE,
  input  logic              iBUS_ACK,
  input  logic [31:0]       iBUS_RDATA,
  input  logic              iFLUSH
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [1:0]       state;
  logic             reqHit;
  logic [IDX_W-1:0] curIdx, reqIdx;
  logic [TAG_W-1:0] curTag, reqTag;
  logic [31:0]      rdData;
  logic [TAG_W-1:0] rdTag;
  logic             rdValid, hit;
  logic             refillDone, writeDone;
  logic             unusedAddrBits;

  assign curIdx         = iMEMADDR[IDX_W+1:2];
  assign curTag         = iMEMADDR[ADDR_W-1:IDX_W+2];
  assign unusedAddrBits = ^iMEMADDR[1:0];
  // The in-flight request's address lives in the bus address register.
  assign reqIdx         = oBUS_ADDR[IDX_W+1:2];
  assign reqTag         = oBUS_ADDR[ADDR_W-1:IDX_W+2];

  assign hit        = rdValid && (rdTag == curTag);
  assign refillDone = (state == ST_REFILL) && iBUS_ACK;
  assign writeDone  = (state == ST_WRITE)  && iBUS_ACK;

  dcache_dm_rv32_store #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W)) uStore (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .rdIdx   (curIdx),
    .rdData  (rdData),
    .rdTag   (rdTag),
    .rdValid (rdValid),
    .wrEn    (refillDone || (writeDone && reqHit)),
    .wrIdx   (reqIdx),
    .wrBe    (refillDone ? BE_ALL : oBUS_BE),
    .wrData  (refillDone ? iBUS_RDATA : oBUS_WDATA),
    .tagWe   (refillDone),
    .wrTag   (reqTag),
    .flush   ((state == ST_IDLE) && iFLUSH)
  );

  // NOTE: combinational outputs get a default before the case so no path infers a latch.
  always_comb begin
    oStallD = 1'b0;
    case (state)
      ST_IDLE:             oStallD = iMEM && (iFLUSH || !iRW || !hit);
      ST_REFILL, ST_WRITE: oStallD = 1'b1;
      default:             oStallD = 1'b0;
    endcase
  end

  // NOTE: every register here is updated with <= so all of them see pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= ST_IDLE;
      reqHit     <= 1'b0;
      oMEMDATA   <= '0;
      oBUS_REQ   <= 1'b0;
      oBUS_WE    <= 1'b0;
      oBUS_ADDR  <= '0;
      oBUS_WDATA <= '0;
      oBUS_BE    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iMEM && !iFLUSH) begin
            if (iRW && hit) begin
              oMEMDATA <= rdData;
            end else begin
              oBUS_REQ  <= 1'b1;
              oBUS_ADDR <= {iMEMADDR[ADDR_W-1:2], 2'b00};
              if (iRW) begin
                state      <= ST_REFILL;
                oBUS_WE    <= BUS_OP_READ;
                oBUS_BE    <= BE_ALL;
                oBUS_WDATA <= '0;
              end else begin
                state      <= ST_WRITE;
                oBUS_WE    <= BUS_OP_WRITE;
                oBUS_BE    <= iBE;
                oBUS_WDATA <= iMEMDATA;
                reqHit     <= hit;
              end
            end
          end
        end
        ST_REFILL: begin
          if (iBUS_ACK) begin
            oMEMDATA <= iBUS_RDATA;
            oBUS_REQ <= 1'b0;
            state    <= ST_RESP;
          end
        end
        ST_WRITE: begin
          if (iBUS_ACK) begin
            oBUS_REQ <= 1'b0;
            state    <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm_rv32.sv
// Self-checking bench for dcache_dm_rv32: acts as core and bus, predicts outputs from a
// coherent-memory model (valid/tag per line, cached data always equals backing memory).
module tb_dcache_dm_rv32;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b1;
  logic              iMEM = 1'b0;
  logic              iRW = 1'b1;
  logic [ADDR_W-1:0] iMEMADDR = '0;
  logic [31:0]       iMEMDATA = '0;
  logic [3:0]        iBE = '0;
  logic [31:0]       oMEMDATA;
  logic              oStallD;
  logic              oBUS_REQ;
  logic              oBUS_WE;
  logic [ADDR_W-1:0] oBUS_ADDR;
  logic [31:0]       oBUS_WDATA;
  logic [3:0]        oBUS_BE;
  logic              iBUS_ACK = 1'b0;
  logic [31:0]       iBUS_RDATA = '0;
  logic              iFLUSH = 1'b0;

  always #5 iCLK = ~iCLK;

  dcache_dm_rv32 #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMEM(iMEM), .iRW(iRW), .iMEMADDR(iMEMADDR),
    .iMEMDATA(iMEMDATA), .iBE(iBE), .oMEMDATA(oMEMDATA), .oStallD(oStallD),
    .oBUS_REQ(oBUS_REQ), .oBUS_WE(oBUS_WE), .oBUS_ADDR(oBUS_ADDR),
    .oBUS_WDATA(oBUS_WDATA), .oBUS_BE(oBUS_BE), .iBUS_ACK(iBUS_ACK),
    .iBUS_RDATA(iBUS_RDATA), .iFLUSH(iFLUSH)
  );

  int nChecks = 0;
  int nErrors = 0;
  int stallTotal = 0;

  // Reference model: which word each line holds, plus the backing memory.
  bit          mValid [DEPTH];
  logic [31:0] mTag   [DEPTH];
  logic [31:0] mem    [logic [31:0]];

  bit          expStall = 1'b0;
  bit          expReq = 1'b0;
  bit          expWe = 1'b0;
  logic [31:0] expMemData = '0;
  logic [31:0] expAddr = '0;
  logic [31:0] expWdata = '0;
  logic [3:0]  expBe = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] w);
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  function automatic bit modelHit(input logic [31:0] addr);
    logic [31:0] w;
    int idx;
    w   = addr >> 2;
    idx = int'(w % DEPTH);
    return mValid[idx] && (mTag[idx] == w / DEPTH);
  endfunction

  function automatic void modelInstall(input logic [31:0] addr);
    logic [31:0] w;
    int idx;
    w   = addr >> 2;
    idx = int'(w % DEPTH);
    mValid[idx] = 1'b1;
    mTag[idx]   = w / DEPTH;
  endfunction

  function automatic void modelInvalidate();
    for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
  endfunction

  // One clock: compare every output against the model mid-cycle, then step past the edge.
  task automatic cycle();
    @(negedge iCLK);
    check("stall", 32'(oStallD), 32'(expStall));
    check("memdata", oMEMDATA, expMemData);
    check("busReq", 32'(oBUS_REQ), 32'(expReq));
    if (expReq) begin
      check("busWe", 32'(oBUS_WE), 32'(expWe));
      check("busAddr", oBUS_ADDR, expAddr);
      check("busBe", 32'(oBUS_BE), 32'(expBe));
      if (expWe) check("busWdata", oBUS_WDATA, expWdata);
    end
    if (oStallD) stallTotal++;
    @(posedge iCLK);
    #1;
  endtask

  // expHit: -1 = no opinion, else the hit/miss the directed test demands of the model.
  task automatic doRead(input logic [31:0] addr, input int n, input int expHit);
    logic [31:0] w;
    bit hit;
    int s0;
    w   = addr >> 2;
    hit = modelHit(addr);
    if (expHit >= 0) check("modelHit", 32'(hit), 32'(expHit));
    iMEM = 1'b1; iRW = 1'b1; iMEMADDR = addr;
    iMEMDATA = $urandom; iBE = 4'($urandom);
    expStall = !hit; expReq = 1'b0;
    s0 = stallTotal;
    cycle();
    if (hit) begin
      expMemData = memRead(w);
      iMEM = 1'b0; expStall = 1'b0;
      return;
    end
    expReq = 1'b1; expWe = 1'b0; expAddr = w << 2; expBe = 4'hF;
    repeat (n - 1) cycle();
    iBUS_ACK = 1'b1; iBUS_RDATA = memRead(w);
    cycle();
    iBUS_ACK = 1'b0; iBUS_RDATA = $urandom;
    expReq = 1'b0; expStall = 1'b0; expMemData = mem[w];
    modelInstall(addr);
    cycle();  // RESP: request still presented, must be ignored
    check("missStalls", 32'(stallTotal - s0), 32'(1 + n));
    iMEM = 1'b0;
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input int n);
    logic [31:0] w, word;
    int s0;
    w = addr >> 2;
    iMEM = 1'b1; iRW = 1'b0; iMEMADDR = addr; iMEMDATA = data; iBE = be;
    expStall = 1'b1; expReq = 1'b0;
    s0 = stallTotal;
    cycle();
    expReq = 1'b1; expWe = 1'b1; expAddr = w << 2; expBe = be; expWdata = data;
    repeat (n - 1) cycle();
    iBUS_ACK = 1'b1; iBUS_RDATA = $urandom;
    cycle();
    iBUS_ACK = 1'b0;
    word = memRead(w);
    for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = data[8*b +: 8];
    mem[w] = word;
    expReq = 1'b0; expStall = 1'b0;
    cycle();
    check("writeStalls", 32'(stallTotal - s0), 32'(1 + n));
    iMEM = 1'b0;
  endtask

  task automatic doFlush(input bit withMem, input logic [31:0] addr);
    iFLUSH = 1'b1; iMEM = withMem; iRW = 1'b1; iMEMADDR = addr;
    expStall = withMem; expReq = 1'b0;
    cycle();
    iFLUSH = 1'b0; iMEM = 1'b0; expStall = 1'b0;
    modelInvalidate();
  endtask

  task automatic idleCycle(input bit stray);
    iMEM = 1'b0; expStall = 1'b0; expReq = 1'b0;
    iBUS_ACK = stray; iBUS_RDATA = $urandom;
    cycle();
    iBUS_ACK = 1'b0;
  endtask

  initial begin
    int r;
    logic [31:0] addr;
    modelInvalidate();
    mem[32'h10 >> 2] = 32'hDEADBEEF;
    mem[32'h30 >> 2] = 32'h11111111;

    // Reset state
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    iRST = 1'b0;
    check("rstBusWe", 32'(oBUS_WE), 32'd0);
    check("rstBusAddr", oBUS_ADDR, 32'd0);
    check("rstBusBe", 32'(oBUS_BE), 32'd0);
    check("rstBusWdata", oBUS_WDATA, 32'd0);
    idleCycle(1'b0);

    // 1: cold miss, 3-cycle bus latency
    doRead(32'h10, 3, 0);
    check("t1Data", oMEMDATA, 32'hDEADBEEF);
    // 2: hit, no bus traffic
    doRead(32'h10, 1, 1);
    idleCycle(1'b0);
    check("t2Data", oMEMDATA, 32'hDEADBEEF);
    // 3: byte write on hit, reread merges
    doWrite(32'h10, 32'h000000AA, 4'b0001, 2);
    doRead(32'h10, 1, 1);
    idleCycle(1'b0);
    check("t3Data", oMEMDATA, 32'hDEADBEAA);
    // 4: aliasing and write-miss no-allocate
    doRead(32'h30, 1, 0);
    check("t4Alias", oMEMDATA, 32'h11111111);
    doRead(32'h10, 2, 0);
    doWrite(32'h50, 32'h12345678, 4'hF, 1);
    doRead(32'h50, 1, 0);
    // 5: flush in IDLE, then a miss
    doRead(32'h10, 2, -1);
    doRead(32'h10, 1, 1);
    doFlush(1'b1, 32'h10);
    doRead(32'h10, 2, 0);
    // 6: reset in the middle of a refill, then a late ACK
    iMEM = 1'b1; iRW = 1'b1; iMEMADDR = 32'h90;
    expStall = 1'b1; expReq = 1'b0;
    cycle();
    expReq = 1'b1; expWe = 1'b0; expAddr = 32'h90; expBe = 4'hF;
    cycle();
    iRST = 1'b1;
    cycle();
    iRST = 1'b0; iMEM = 1'b0;
    expReq = 1'b0; expStall = 1'b0; expMemData = '0;
    modelInvalidate();
    idleCycle(1'b1);
    idleCycle(1'b0);
    check("t6BusAddr", oBUS_ADDR, 32'd0);
    doRead(32'h10, 1, 0);

    // Randomized traffic over a small address window so lines alias and hit often
    repeat (400) begin
      r    = $urandom_range(0, 99);
      addr = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = addr | 32'h8000_0000;
      if (r < 45)      doRead(addr, $urandom_range(1, 4), -1);
      else if (r < 82) doWrite(addr, $urandom, 4'($urandom), $urandom_range(1, 4));
      else if (r < 88) doFlush(1'($urandom), addr);
      else             idleCycle(1'($urandom));
    end
    idleCycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
